// File: rtl/symbol_aligner.sv
// symbol_aligner: buffers raw I/Q, cuts the CP-stripped OFDM
// symbol at window_start + theta + L and streams it to the FFT.
package symbol_aligner_pkg;
  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_STREAM
  } st_t;
endpackage

module symbol_aligner #(
  parameter int N          = 256,
  parameter int L          = 16,
  parameter int DW         = 16,
  parameter int AW         = 10,
  parameter int WIN_OFFSET = 272
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_i,
  input  logic signed [DW-1:0] in_q,
  input  logic                 theta_valid,
  input  logic [7:0]           theta_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_i,
  output logic signed [DW-1:0] out_q,
  output logic                 out_first,
  output logic                 out_last,
  output logic [15:0]          sym_cnt,
  output logic                 drop_err,
  output logic                 overrun_err
);
  import symbol_aligner_pkg::*;

  localparam int DEPTH = 1 << AW;
  localparam int JW    = $clog2(N) + 1;
  localparam int SW    = 2 * DW;

  logic [SW-1:0] mem [DEPTH];
  logic [SW-1:0] ram_q;

  logic [23:0] wr_cnt;
  logic [23:0] win_base;
  logic [23:0] calc;
  logic [23:0] fq [2];
  logic        wp;
  logic        rp;
  logic [1:0]  fcnt;
  logic        push;
  logic        fpop;

  st_t           st;
  logic [23:0]   start;
  logic [JW-1:0] rd_j;
  logic [23:0]   rd_addr;
  logic [23:0]   diff;
  logic [23:0]   sdiff;
  logic          written;
  logic          stale;
  logic          late;
  logic          more;
  logic          active;
  logic          ovr;
  logic          rd_en;
  logic          pop_out;
  logic [1:0]    stored;

  logic          rd_pend;
  logic          pend_first;
  logic          pend_last;
  logic          sk_valid;
  logic          sk_first;
  logic          sk_last;
  logic [SW-1:0] sk_d;
  logic          hold;
  logic          mv_sk;
  logic          mv_ram;

  always_comb begin
    calc = 24'(WIN_OFFSET) + win_base
         + 24'(theta_in) + 24'(L);
    push = theta_valid && (fcnt != 2'd2);
    fpop = (st == S_IDLE) && (fcnt != 2'd0);

    rd_addr = start + 24'(rd_j);
    diff    = wr_cnt - rd_addr;
    sdiff   = wr_cnt - start;
    // bit 23 set means the address lies ahead
    // of the write pointer (not yet written)
    written = (diff != '0) && !diff[23];
    stale   = !diff[23] && (diff >= 24'(DEPTH));
    late    = !sdiff[23]
           && (sdiff > 24'(DEPTH - N));
    more    = rd_j < JW'(N);
    active  = (st == S_WAIT) || (st == S_STREAM);
    ovr     = active && more && stale;

    pop_out = out_valid && out_ready;
    // items held after this edge; one read may
    // be in flight only if a slot stays free
    stored  = 2'(out_valid) + 2'(sk_valid)
            + 2'(rd_pend) - 2'(pop_out);
    rd_en   = active && more && written
           && !stale && (stored <= 2'd1);

    hold    = out_valid && !out_ready;
    mv_sk   = !hold && sk_valid;
    mv_ram  = !hold && !sk_valid && rd_pend;
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem[wr_cnt[AW-1:0]] <= {in_i, in_q};
    end
    if (rd_en) begin
      ram_q <= mem[rd_addr[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt   <= '0;
      win_base <= '0;
      fq[0]    <= '0;
      fq[1]    <= '0;
      wp       <= 1'b0;
      rp       <= 1'b0;
      fcnt     <= '0;
      drop_err <= 1'b0;
    end else begin
      if (in_valid) begin
        wr_cnt <= wr_cnt + 24'd1;
      end
      if (theta_valid) begin
        win_base <= win_base + 24'(N);
        if (!push) begin
          drop_err <= 1'b1;
        end
      end
      if (push) begin
        fq[wp] <= calc;
        wp     <= ~wp;
      end
      if (fpop) begin
        rp <= ~rp;
      end
      fcnt <= fcnt + 2'(push) - 2'(fpop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= S_IDLE;
      start       <= '0;
      rd_j        <= '0;
      rd_pend     <= 1'b0;
      pend_first  <= 1'b0;
      pend_last   <= 1'b0;
      sk_valid    <= 1'b0;
      sk_first    <= 1'b0;
      sk_last     <= 1'b0;
      sk_d        <= '0;
      out_valid   <= 1'b0;
      out_i       <= '0;
      out_q       <= '0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      sym_cnt     <= '0;
      overrun_err <= 1'b0;
    end else begin
      rd_pend <= rd_en;
      if (rd_en) begin
        rd_j       <= rd_j + JW'(1);
        pend_first <= (rd_j == '0);
        pend_last  <= (rd_j == JW'(N - 1));
      end

      unique case (st)
        S_IDLE: begin
          if (fpop) begin
            start <= fq[rp];
            rd_j  <= '0;
            st    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (late) begin
            overrun_err <= 1'b1;
            st          <= S_IDLE;
          end else begin
            st <= S_WAIT;
          end
        end
        S_WAIT, S_STREAM: begin
          if (ovr) begin
            overrun_err <= 1'b1;
            st          <= S_IDLE;
          end else if (pop_out && out_last) begin
            sym_cnt <= sym_cnt + 16'd1;
            st      <= S_IDLE;
          end else if (rd_en) begin
            st <= S_STREAM;
          end
        end
        default: st <= S_IDLE;
      endcase

      if (ovr) begin
        out_valid <= 1'b0;
        sk_valid  <= 1'b0;
        rd_pend   <= 1'b0;
      end else begin
        unique case (1'b1)
          hold: begin
            if (rd_pend) begin
              sk_valid <= 1'b1;
              sk_d     <= ram_q;
              sk_first <= pend_first;
              sk_last  <= pend_last;
            end
          end
          mv_sk: begin
            out_valid <= 1'b1;
            out_i     <= sk_d[SW-1:DW];
            out_q     <= sk_d[DW-1:0];
            out_first <= sk_first;
            out_last  <= sk_last;
            sk_valid  <= rd_pend;
            sk_d      <= ram_q;
            sk_first  <= pend_first;
            sk_last   <= pend_last;
          end
          mv_ram: begin
            out_valid <= 1'b1;
            out_i     <= ram_q[SW-1:DW];
            out_q     <= ram_q[DW-1:0];
            out_first <= pend_first;
            out_last  <= pend_last;
          end
          default: out_valid <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_symbol_aligner.sv
// tb_symbol_aligner: directed bench for symbol_aligner
// driving a ramp (I=n, Q=-n) and theta pulses.
module tb_symbol_aligner;
  localparam int N = 256;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [15:0] in_i;
  logic signed [15:0] in_q;
  logic               theta_valid;
  logic [7:0]         theta_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_i;
  logic signed [15:0] out_q;
  logic               out_first;
  logic               out_last;
  logic [15:0]        sym_cnt;
  logic               drop_err;
  logic               overrun_err;

  int checks = 0;
  int failures = 0;
  int n = 0;
  int rmode = 0;
  int starts[$];
  int cur = 0;
  int ej = 0;
  int sdone = 0;
  int acc = 0;
  int c = 0;

  always #5 clk = ~clk;

  symbol_aligner dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_i(in_i),
    .in_q(in_q),
    .theta_valid(theta_valid),
    .theta_in(theta_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_i(out_i),
    .out_q(out_q),
    .out_first(out_first),
    .out_last(out_last),
    .sym_cnt(sym_cnt),
    .drop_err(drop_err),
    .overrun_err(overrun_err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input logic tv,
                      input logic [7:0] th);
    int v;
    logic have;
    @(negedge clk);
    case (rmode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 9) >= 3);
    endcase
    have = (ej != 0) || (starts.size() != 0);
    if (!have) begin
      chk("idle_valid", 64'(out_valid), 64'd0);
    end else if (out_valid) begin
      v = (ej == 0) ? starts[0] : cur + ej;
      chk("sample",
          64'({out_i, out_q, out_first, out_last}),
          64'({16'(v), 16'(-v),
               ej == 0, ej == N - 1}));
      if (out_ready) begin
        if (ej == 0) cur = starts.pop_front();
        ej++;
        acc++;
        if (ej == N) begin
          ej = 0;
          sdone++;
        end
      end
    end
    in_valid    = 1'b1;
    in_i        = 16'(n);
    in_q        = 16'(-n);
    theta_valid = tv;
    theta_in    = th;
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) tick(1'b0, 8'd0);
  endtask

  task automatic pulse(input logic [7:0] th);
    tick(1'b1, th);
  endtask

  task automatic run_syms(input int k,
                          input int budget,
                          input string tag);
    int cc = 0;
    while (sym_cnt != 16'(k) && cc < budget) begin
      tick(1'b0, 8'd0);
      cc++;
    end
    chk(tag, 64'(sym_cnt), 64'(k));
  endtask

  task automatic do_reset(input string tag);
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_i        = '0;
    in_q        = '0;
    theta_valid = 1'b0;
    theta_in    = '0;
    out_ready   = 1'b0;
    #1;
    chk(tag, 64'({out_valid, out_i, out_q,
                  out_first, out_last, sym_cnt,
                  drop_err, overrun_err}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n     = 0;
    starts.delete();
    ej    = 0;
    sdone = 0;
    acc   = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    do_reset("reset_state");

    // back-to-back symbols, theta=0 each window
    rmode = 1;
    run_to(528);  starts.push_back(288);  pulse(8'd0);
    run_to(784);  starts.push_back(544);  pulse(8'd0);
    run_to(1040); starts.push_back(800);  pulse(8'd0);
    run_to(1296); starts.push_back(1056); pulse(8'd0);
    c = 0;
    while (!(sdone == 3 && ej == 100) && c < 2000) begin
      tick(1'b0, 8'd0);
      c++;
    end
    chk("b2b_at_j100", 64'(ej), 64'd100);
    chk("b2b_sym_cnt", 64'(sym_cnt), 64'd3);
    chk("b2b_errs", 64'({drop_err, overrun_err}), 64'd0);

    // reset in the middle of the fourth symbol
    do_reset("mid_symbol_reset");

    // ramp, theta=5 at sample 528 -> I=293..548
    rmode = 1;
    run_to(528); starts.push_back(293); pulse(8'd5);
    run_syms(1, 800, "ramp_sym_cnt");
    chk("ramp_accepted", 64'(acc), 64'd256);
    chk("ramp_model_done", 64'(sdone), 64'd1);

    // random back-pressure
    do_reset("reset_rand");
    rmode = 2;
    run_to(528); starts.push_back(288); pulse(8'd0);
    run_to(784); starts.push_back(544); pulse(8'd0);
    run_syms(2, 2500, "rand_sym_cnt");
    chk("rand_accepted", 64'(acc), 64'd512);
    chk("rand_errs", 64'({drop_err, overrun_err}), 64'd0);

    // queue overflow while output is stalled
    do_reset("reset_drop");
    rmode = 0;
    run_to(528); starts.push_back(288); pulse(8'd0);
    run_to(540);
    starts.push_back(544); pulse(8'd0);
    starts.push_back(800); pulse(8'd0);
    pulse(8'd0);
    run_to(560);
    chk("drop_err_set", 64'(drop_err), 64'd1);
    chk("drop_held_valid", 64'(out_valid), 64'd1);
    chk("drop_no_overrun", 64'(overrun_err), 64'd0);
    rmode = 1;
    run_syms(3, 1500, "drop_sym_cnt");
    chk("drop_accepted", 64'(acc), 64'd768);
    chk("drop_err_sticky", 64'(drop_err), 64'd1);

    // long stall mid-symbol -> overrun
    do_reset("reset_ovr");
    rmode = 1;
    run_to(528); starts.push_back(288); pulse(8'd0);
    run_to(560);
    rmode = 0;
    run_to(1760);
    chk("ovr_err_set", 64'(overrun_err), 64'd1);
    chk("ovr_flushed", 64'(out_valid), 64'd0);
    chk("ovr_no_sym", 64'(sym_cnt), 64'd0);
    chk("ovr_partial",
        64'(acc > 0 && acc < N), 64'd1);
    // windows 1,2 are stale, window 3 is served
    starts.delete();
    ej = 0;
    starts.push_back(1056);
    rmode = 1;
    pulse(8'd0);
    pulse(8'd0);
    pulse(8'd0);
    run_syms(1, 1500, "ovr_next_sym_cnt");
    chk("ovr_next_done", 64'(sdone), 64'd1);
    chk("ovr_no_drop", 64'(drop_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
